// File: rtl/operand_sequencer.sv
// operand_sequencer: assembles a 4-byte operation frame, issues it to the
// datapath stage, waits (with a watchdog) for the result and hands it
// downstream on a valid/ready handshake.
module operand_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       dp_start,
    output logic [1:0] dp_sel,
    output logic [7:0] dp_a,
    output logic [7:0] dp_b,
    output logic [3:0] dp_c,
    output logic [3:0] dp_d,
    input  logic       dp_ready,
    input  logic [7:0] dp_result,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       err_timeout,
    output logic [7:0] done_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Last counter value of the WAIT window: the watchdog fires at the end
    // of WAIT cycle number TIMEOUT, when the counter holds TIMEOUT-1.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] byte_idx;
    logic [7:0] wd_cnt;
    logic       accept;
    logic       capture;
    logic       deliver;
    logic       wd_expire;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake/strobe outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dp_start  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        wd_expire = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (byte_idx == 2'd3) begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                dp_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the watchdog's last cycle still wins.
                if (dp_ready) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUT;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    deliver   = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Operand registers and frame byte index; index wraps 3 -> 0 on byte3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            dp_sel   <= '0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_c     <= '0;
            dp_d     <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    dp_sel <= in_data[1:0];
                2'd1:    dp_a   <= in_data;
                2'd2:    dp_b   <= in_data;
                default: {dp_c, dp_d} <= in_data;
            endcase
        end
    end

    // Watchdog counter: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Result capture, sticky timeout flag and delivered-result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            err_timeout <= 1'b0;
            done_cnt    <= '0;
        end else begin
            if (capture) begin
                out_data <= dp_result;
            end
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end
            if (deliver) begin
                done_cnt <= done_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer. Inputs are driven and outputs are
// observed on the falling edge; the DUT acts on the rising edge.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       dp_start;
    logic [1:0] dp_sel;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic [3:0] dp_c;
    logic [3:0] dp_d;
    logic       dp_ready;
    logic [7:0] dp_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       err_timeout;
    logic [7:0] done_cnt;

    int errors = 0;
    int checks = 0;

    operand_sequencer #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .dp_start    (dp_start),
        .dp_sel      (dp_sel),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .dp_c        (dp_c),
        .dp_d        (dp_d),
        .dp_ready    (dp_ready),
        .dp_result   (dp_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err_timeout (err_timeout),
        .done_cnt    (done_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus only: present one byte for one rising edge after `gap` idle cycles.
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        for (int unsigned i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Stimulus only: a full frame; returns at the falling edge of the ISSUE cycle.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int unsigned gap);
        send_byte(b0, 0);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        dp_ready = 1'b0; dp_result = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if ({dp_start, out_valid, err_timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {dp_start, out_valid, err_timeout});
        end
        checks++;
        if ({dp_sel, dp_a, dp_b, dp_c, dp_d} !== 26'h0) begin
            errors++; $display("FAIL reset_operands: got %h want 0", {dp_sel, dp_a, dp_b, dp_c, dp_d});
        end
        checks++;
        if ({out_data, done_cnt} !== 16'h0000) begin
            errors++; $display("FAIL reset_out: got %h want 0000", {out_data, done_cnt});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send_frame(8'h03, 8'h00, 8'hFF, 8'h0A, 0);
        checks++;
        if (dp_start !== 1'b1) begin errors++; $display("FAIL basic_start: got %b want 1", dp_start); end
        checks++;
        if ({dp_sel, dp_a, dp_b, dp_c, dp_d} !== {2'd3, 8'h00, 8'hFF, 4'h0, 4'hA}) begin
            errors++; $display("FAIL basic_operands: got %h want %h",
                {dp_sel, dp_a, dp_b, dp_c, dp_d}, {2'd3, 8'h00, 8'hFF, 4'h0, 4'hA});
        end
        @(negedge clk);  // WAIT 1
        checks++;
        if (dp_start !== 1'b0) begin errors++; $display("FAIL basic_start_width: got %b want 0", dp_start); end
        @(negedge clk);  // WAIT 2
        @(negedge clk);  // WAIT 3
        dp_ready = 1'b1; dp_result = 8'h5A;
        @(negedge clk);  // OUT
        dp_ready = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL basic_out: got %b/%h want 1/5a", out_valid, out_data);
        end
        @(negedge clk);  // back in LOAD
        checks++;
        if ({in_ready, out_valid, done_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            errors++; $display("FAIL basic_done: got %b/%b/%0d want 1/0/1", in_ready, out_valid, done_cnt);
        end
    endtask

    task automatic test_gaps_early_ready;
        out_ready = 1'b1;
        send_frame(8'h03, 8'h00, 8'hFF, 8'h0A, 2);
        checks++;
        if ({dp_start, dp_sel, dp_a, dp_b, dp_c, dp_d} !== {1'b1, 2'd3, 8'h00, 8'hFF, 4'h0, 4'hA}) begin
            errors++; $display("FAIL gaps_operands: got %h want %h",
                {dp_start, dp_sel, dp_a, dp_b, dp_c, dp_d}, {1'b1, 2'd3, 8'h00, 8'hFF, 4'h0, 4'hA});
        end
        dp_ready = 1'b1; dp_result = 8'h33;   // must be ignored in ISSUE
        @(negedge clk);  // WAIT 1
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_issue_ready_ignored: got %b want 0", out_valid); end
        dp_result = 8'hC3;
        @(negedge clk);  // OUT
        dp_ready = 1'b0;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'hC3}) begin
            errors++; $display("FAIL gaps_out: got %b/%h want 1/c3", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'd2) begin errors++; $display("FAIL gaps_done: got %0d want 2", done_cnt); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_frame(8'h01, 8'h12, 8'h34, 8'h56, 0);
        checks++;
        if ({dp_sel, dp_a, dp_b, dp_c, dp_d} !== {2'd1, 8'h12, 8'h34, 4'h5, 4'h6}) begin
            errors++; $display("FAIL bp_operands: got %h want %h",
                {dp_sel, dp_a, dp_b, dp_c, dp_d}, {2'd1, 8'h12, 8'h34, 4'h5, 4'h6});
        end
        @(negedge clk);  // WAIT 1
        dp_ready = 1'b1; dp_result = 8'h77;
        @(negedge clk);  // OUT 1
        dp_ready = 1'b0; dp_result = 8'h00;
        for (int unsigned i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_data, in_ready} !== {1'b1, 8'h77, 1'b0}) begin
                errors++; $display("FAIL bp_stall[%0d]: got %b/%h/%b want 1/77/0", i, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt !== 8'd2) begin errors++; $display("FAIL bp_no_early_count: got %0d want 2", done_cnt); end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, done_cnt} !== {1'b0, 1'b1, 8'd3}) begin
            errors++; $display("FAIL bp_release: got %b/%b/%0d want 0/1/3", out_valid, in_ready, done_cnt);
        end
    endtask

    task automatic test_watchdog;
        out_ready = 1'b1; dp_ready = 1'b0;
        send_frame(8'h02, 8'h11, 8'h22, 8'h33, 0);
        for (int unsigned k = 1; k <= 16; k++) begin
            @(negedge clk);  // WAIT k
            checks++;
            if ({err_timeout, out_valid, in_ready} !== 3'b000) begin
                errors++; $display("FAIL wd_wait[%0d]: got %b want 000", k, {err_timeout, out_valid, in_ready});
            end
        end
        @(negedge clk);
        checks++;
        if ({err_timeout, out_valid, in_ready} !== 3'b101) begin
            errors++; $display("FAIL wd_expire: got %b want 101", {err_timeout, out_valid, in_ready});
        end
        send_frame(8'h00, 8'h05, 8'h06, 8'h78, 0);
        @(negedge clk);  // WAIT 1
        dp_ready = 1'b1; dp_result = 8'h99;
        @(negedge clk);  // OUT
        dp_ready = 1'b0;
        checks++;
        if ({out_valid, out_data, err_timeout} !== {1'b1, 8'h99, 1'b1}) begin
            errors++; $display("FAIL wd_next_frame: got %b/%h/%b want 1/99/1", out_valid, out_data, err_timeout);
        end
        @(negedge clk);
        checks++;
        if ({done_cnt, err_timeout} !== {8'd4, 1'b1}) begin
            errors++; $display("FAIL wd_sticky: got %0d/%b want 4/1", done_cnt, err_timeout);
        end
    endtask

    task automatic test_timeout_race;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        send_frame(8'h03, 8'hAA, 8'hBB, 8'hCC, 0);
        repeat (16) @(negedge clk);  // WAIT 16
        dp_ready = 1'b1; dp_result = 8'h42;
        @(negedge clk);
        dp_ready = 1'b0;
        checks++;
        if ({out_valid, out_data, err_timeout} !== {1'b1, 8'h42, 1'b0}) begin
            errors++; $display("FAIL race_capture: got %b/%h/%b want 1/42/0", out_valid, out_data, err_timeout);
        end
        @(negedge clk);
        checks++;
        if ({done_cnt, err_timeout} !== {8'd1, 1'b0}) begin
            errors++; $display("FAIL race_done: got %0d/%b want 1/0", done_cnt, err_timeout);
        end
    endtask

    task automatic test_reset_midframe;
        out_ready = 1'b1;
        send_byte(8'h01, 0);
        send_byte(8'hEE, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dp_sel, dp_a, done_cnt} !== 18'h0) begin
            errors++; $display("FAIL rst_async: got %h want 0", {dp_sel, dp_a, done_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h02, 8'h10, 8'h20, 8'h3C, 0);
        checks++;
        if ({dp_start, dp_sel, dp_a, dp_b, dp_c, dp_d} !== {1'b1, 2'd2, 8'h10, 8'h20, 4'h3, 4'hC}) begin
            errors++; $display("FAIL rst_new_frame: got %h want %h",
                {dp_start, dp_sel, dp_a, dp_b, dp_c, dp_d}, {1'b1, 2'd2, 8'h10, 8'h20, 4'h3, 4'hC});
        end
        @(negedge clk);
        dp_ready = 1'b1; dp_result = 8'h01;
        @(negedge clk);
        dp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'd1) begin errors++; $display("FAIL rst_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap;
        logic [7:0] v;
        out_ready = 1'b1;
        for (int unsigned i = 1; i < 256; i++) begin
            v = 8'(i);
            send_frame({6'd0, v[1:0]}, v, ~v, v, 0);
            @(negedge clk);  // WAIT 1
            dp_ready = 1'b1; dp_result = v ^ 8'h5A;
            @(negedge clk);  // OUT
            dp_ready = 1'b0;
            checks++;
            if ({out_valid, out_data} !== {1'b1, v ^ 8'h5A}) begin
                errors++; $display("FAIL wrap_out[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, v ^ 8'h5A);
            end
            @(negedge clk);
            if (i == 254) begin
                checks++;
                if (done_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", done_cnt); end
            end
        end
        checks++;
        if (done_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", done_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gaps_early_ready;
        test_backpressure;
        test_watchdog;
        test_timeout_race;
        test_reset_midframe;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Upstream feeder for the `datapath` compute stage. It assembles one operation frame from a byte stream, drives the `datapath` operand and select inputs, and pulses `start`. It then waits for the stage's `ready`, captures `result`, and offers it downstream on a valid/ready handshake. A watchdog flags a `datapath` that never answers.

## Interface
- `TIMEOUT`, default 16: maximum number of WAIT cycles before the block gives up on a frame (legal range 2..255).
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: byte on `in_data` is valid.
- `in_data` input 8: frame byte.
- `in_ready` output 1: block accepts a byte this cycle.
- `dp_start` output 1: one-cycle start pulse to `datapath`.
- `dp_sel` output 2: operation select.
- `dp_a` output 8: operand a.
- `dp_b` output 8: operand b.
- `dp_c` output 4: operand c.
- `dp_d` output 4: operand d.
- `dp_ready` input 1: `datapath` result valid.
- `dp_result` input 8: `datapath` result.
- `out_valid` output 1: `out_data` holds a captured result.
- `out_data` output 8: captured result.
- `out_ready` input 1: downstream accepts the result.
- `err_timeout` output 1: sticky watchdog flag.
- `done_cnt` output 8: count of results delivered downstream.

## Operation
- Frame layout is 4 bytes, taken in order:
  - byte0[1:0] → `dp_sel`; byte0[7:2] ignored.
  - byte1 → `dp_a`.
  - byte2 → `dp_b`.
  - byte3[7:4] → `dp_c`; byte3[3:0] → `dp_d`.
- A byte is accepted on a rising edge where `in_valid & in_ready`. Gaps in `in_valid` are allowed.
- Each byte goes directly into its operand register as it is accepted.
- Operand registers hold their values from acceptance until the next frame overwrites them. They are stable throughout ISSUE and WAIT.
- FSM states:
  - **LOAD**: `in_ready`=1, 2-bit byte index 0..3. Accepting byte3 → ISSUE, index → 0.
  - **ISSUE**: `dp_start`=1 for exactly this one cycle; `dp_ready` is ignored. → WAIT; watchdog counter cleared to 0.
  - **WAIT**: counter increments each cycle.
    - `dp_ready`=1 → capture `dp_result` into `out_data`, → OUT.
    - Otherwise, counter == `TIMEOUT`-1 → set `err_timeout`, discard the frame, → LOAD.
    - If `dp_ready` and timeout hit in the same cycle, `dp_ready` wins (the result is captured, no error).
  - **OUT**: `out_valid`=1 and `out_data` held until `out_ready`=1. On that handshake: `done_cnt` += 1 (wraps 255 → 0), → LOAD.
- `in_ready` is 0 in ISSUE, WAIT and OUT. Backpressure never drops or overwrites a result.
- `err_timeout` is sticky; only reset clears it. It does not stall later frames.
- Outputs `in_ready`, `dp_start` and `out_valid` decode directly from the state register. All other outputs are registers.

## Timing
- Reset values:
  - state LOAD, byte index 0.
  - `in_ready`=1.
  - `dp_start`=0, `dp_sel`=0, `dp_a`=0, `dp_b`=0, `dp_c`=0, `dp_d`=0.
  - `out_valid`=0, `out_data`=0.
  - `err_timeout`=0, `done_cnt`=0.
  - Watchdog counter 0.
- Reset asserted mid-operation clears everything immediately. Any partial frame or pending result is discarded.
- The edge that accepts byte3 is followed by `dp_start` high for the next cycle only.
- The earliest `dp_ready` that counts is sampled on the edge ending the first WAIT cycle. That is 2 cycles after byte3 is accepted.
- The edge that captures `dp_result` is followed by `out_valid`=1 in the next cycle.
- The `out_ready` handshake edge is followed by `in_ready`=1 in the next cycle.
- Minimum frame period with no stalls is 7 cycles: 4 LOAD + 1 ISSUE + 1 WAIT + 1 OUT.
- Timeout: `err_timeout` rises on the edge ending WAIT cycle number `TIMEOUT`. `in_ready` is 1 in the following cycle.

## Test plan
- **Basic frame.** Send bytes 03, 00, FF, 0A back-to-back; bench asserts `dp_ready` with `dp_result`=5A three cycles after `dp_start`; `out_ready`=1.
  - Required: during `dp_start`, `dp_sel`=3, `dp_a`=00, `dp_b`=FF, `dp_c`=0, `dp_d`=A.
  - Required: `dp_start` is high exactly one cycle; `out_data`=5A; `done_cnt`=1.
- **Input gaps and early ready.** Drop `in_valid` for 2 cycles between every byte; also hold `dp_ready` high during ISSUE.
  - Required: the operands are identical to the no-gap case.
  - Required: the ISSUE-cycle `dp_ready` is ignored, and the result is captured in WAIT.
- **Downstream backpressure.** Hold `out_ready`=0 for 5 cycles in OUT.
  - Required: `out_valid` stays 1 and `out_data` is stable for the whole stall.
  - Required: `in_ready`=0 throughout; the result is accepted once `out_ready` rises.
- **Watchdog.** `TIMEOUT`=16 and `dp_ready` is never asserted.
  - Required: `err_timeout` is set after 16 WAIT cycles; `out_valid` never rises; `in_ready` returns to 1.
  - Required: a following normal frame completes, and `err_timeout` stays 1.
- **Timeout race.** `dp_ready` arrives in exactly WAIT cycle 16.
  - Required: the result is delivered and `err_timeout` stays 0.
- **Reset and wrap.** Assert `rst_n` low after 2 bytes of a frame, then send a full frame.
  - Required: the new frame's operands are correct, with no stale bytes from the interrupted frame.
  - Then run 256 frames. Required: `done_cnt` wraps to 00.
